// File: rtl/sram_responder_pkg.sv
// rtl/sram_responder_pkg.sv - FSM states, counter width and SRAM control encoding for sram_responder
package sram_responder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_DONE,
    WR,
    WR_REC
  } state_t;

  localparam int CNT_WIDTH = 4;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic ub_n;
    logic lb_n;
  } sram_ctrl_t;

  localparam sram_ctrl_t CTRL_INACTIVE = '1;

endpackage

// File: rtl/sram_responder_if.sv
// rtl/sram_responder_if.sv - test controller memory port seen by sram_responder
interface sram_responder_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] address;
  logic [BE_WIDTH-1:0]   byteenable;
  logic                  read;
  logic                  write;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  readdataready;
  logic                  waitrequest;

  modport master (
    output address, byteenable, read, write, writedata,
    input  readdata, readdataready, waitrequest
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output readdata, readdataready, waitrequest
  );

endinterface

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - memory-port responder driving one timed access per request on an async 16-bit SRAM
// Optional SRAM_RESPONDER_STATS_EN adds saturating rd_count/wr_count outputs.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int RD_WAIT    = 2,
  parameter int WR_PULSE   = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  sram_responder_if.slave       bus,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_dq_out,
  output logic                  sram_dq_oe,
  input  logic [DATA_WIDTH-1:0] sram_dq_in,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  sram_ub_n,
`ifdef SRAM_RESPONDER_STATS_EN
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count,
`endif
  output logic                  sram_lb_n
);

  state_t               state, state_d;
  logic [CNT_WIDTH-1:0] cnt, cnt_d;
  logic [BE_WIDTH-1:0]  be_q, be_d;
  sram_ctrl_t           ctrl_q, ctrl_d;
  logic                 dq_oe_d;
  logic                 accept;

  assign bus.waitrequest = reset || (state != IDLE);
  assign accept          = (bus.read || bus.write) && !bus.waitrequest;

  assign sram_ce_n = ctrl_q.ce_n;
  assign sram_oe_n = ctrl_q.oe_n;
  assign sram_we_n = ctrl_q.we_n;
  assign sram_ub_n = ctrl_q.ub_n;
  assign sram_lb_n = ctrl_q.lb_n;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    be_d    = accept ? bus.byteenable : be_q;
    ctrl_d  = CTRL_INACTIVE;
    dq_oe_d = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          if (bus.write) begin
            state_d = WR;
            cnt_d   = CNT_WIDTH'(WR_PULSE - 1);
          end else begin
            state_d = RD;
            cnt_d   = CNT_WIDTH'(RD_WAIT);
          end
        end
      end
      RD: begin
        if (cnt == '0) state_d = RD_DONE;
        else           cnt_d   = cnt - CNT_WIDTH'(1);
      end
      RD_DONE: state_d = IDLE;
      WR: begin
        if (cnt == '0) state_d = WR_REC;
        else           cnt_d   = cnt - CNT_WIDTH'(1);
      end
      WR_REC:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are decoded from the state being entered so the pins change on the same edge as the FSM.
    unique case (state_d)
      RD: begin
        ctrl_d.ce_n = 1'b0;
        ctrl_d.oe_n = 1'b0;
        ctrl_d.ub_n = ~be_d[1];
        ctrl_d.lb_n = ~be_d[0];
      end
      WR, WR_REC: begin
        ctrl_d.ce_n = 1'b0;
        ctrl_d.we_n = (state_d == WR) ? 1'b0 : 1'b1;
        ctrl_d.ub_n = ~be_d[1];
        ctrl_d.lb_n = ~be_d[0];
        dq_oe_d     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      be_q              <= '0;
      ctrl_q            <= CTRL_INACTIVE;
      sram_dq_oe        <= 1'b0;
      sram_addr         <= '0;
      sram_dq_out       <= '0;
      bus.readdata      <= '0;
      bus.readdataready <= 1'b0;
    end else begin
      state             <= state_d;
      cnt               <= cnt_d;
      be_q              <= be_d;
      ctrl_q            <= ctrl_d;
      sram_dq_oe        <= dq_oe_d;
      bus.readdataready <= (state_d == RD_DONE);
      if (accept)              sram_addr    <= bus.address;
      if (accept && bus.write) sram_dq_out  <= bus.writedata;
      if (state == RD && cnt == '0) bus.readdata <= sram_dq_in;
    end
  end

`ifdef SRAM_RESPONDER_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (accept && bus.write && wr_count != 16'hFFFF)  wr_count <= wr_count + 16'd1;
      if (accept && !bus.write && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
    end
  end
`endif

endmodule
